// File: rtl/uart_sample_assembler_pkg.sv
// Shared constants and assembly state encoding for the UART sample assembler.
package uart_sample_assembler_pkg;

    localparam int BYTE_W           = 8;
    localparam int SAMPLE_W_DEFAULT = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } asm_state_t;

endpackage

// File: rtl/uart_sample_assembler_buffer.sv
// One-entry valid/ready holding register for completed samples, with overrun pulse.
module sample_out_buffer
    import uart_sample_assembler_pkg::*;
#(
    parameter int width = SAMPLE_W_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic        [width-1:0] word,
    input  logic                    ready,
    output logic signed [width-1:0] data,
    output logic                    valid,
    output logic                    overrun
);

    logic free;

    // A sample leaving in this cycle frees the slot for a sample arriving in the same cycle.
    assign free = !valid || ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= load && !free;
            if (load && free) begin
                data  <= word;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_sample_assembler.sv
// Packs little-endian UART bytes into signed samples; drops stale partial samples after a byte gap.
//   state   | meaning
//   IDLE    | no partial sample held (byte counter = 0)
//   COLLECT | partial sample held, inter-byte timer running
module uart_sample_assembler
    import uart_sample_assembler_pkg::*;
#(
    parameter int width        = SAMPLE_W_DEFAULT,
    parameter int BYTE_TIMEOUT = 100000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic       [BYTE_W-1:0] rx_data,
    input  logic                    rx_valid,
    output logic signed [width-1:0] sample_out,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun,
    output logic                    timeout_err
);

    localparam int NBYTES = width / BYTE_W;
    localparam int CW     = $clog2(NBYTES);
    localparam int TW     = $clog2(BYTE_TIMEOUT + 1);

    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
    localparam logic [TW-1:0] T_LAST    = TW'(BYTE_TIMEOUT - 1);

    asm_state_t       state_q;
    logic [CW-1:0]    bcnt;
    logic [TW-1:0]    tcnt;
    logic [width-1:0] asm_q;
    logic [width-1:0] asm_wr;
    logic             last;
    logic             done;

    always_comb begin
        asm_wr = asm_q;
        asm_wr[bcnt*BYTE_W +: BYTE_W] = rx_data;
        last = (bcnt == LAST_BYTE);
        done = rx_valid && last;
    end

    // A byte arriving in the expiry cycle takes priority over the timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bcnt        <= '0;
            tcnt        <= '0;
            asm_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (rx_valid) begin
                tcnt <= '0;
                if (last) begin
                    bcnt    <= '0;
                    asm_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    bcnt    <= bcnt + 1'b1;
                    asm_q   <= asm_wr;
                    state_q <= COLLECT;
                end
            end else if (state_q == COLLECT) begin
                if (tcnt == T_LAST) begin
                    bcnt        <= '0;
                    tcnt        <= '0;
                    asm_q       <= '0;
                    state_q     <= IDLE;
                    timeout_err <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

    sample_out_buffer #(.width(width)) u_buf (
        .clock   (clock),
        .reset   (reset),
        .load    (done),
        .word    (asm_wr),
        .ready   (sample_ready),
        .data    (sample_out),
        .valid   (sample_valid),
        .overrun (overrun)
    );

endmodule

// File: tb/tb_uart_sample_assembler.sv
// Directed self-checking bench for uart_sample_assembler (16-bit samples, 20-cycle byte timeout).
module tb_uart_sample_assembler;

    logic              clock;
    logic              reset;
    logic        [7:0] rx_data;
    logic              rx_valid;
    logic signed [15:0] sample_out;
    logic              sample_valid;
    logic              sample_ready;
    logic              overrun;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;

    uart_sample_assembler #(.width(16), .BYTE_TIMEOUT(20)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    initial begin
        reset        = 1'b0;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        sample_ready = 1'b0;
        #12;
        check("rst_out", 32'(sample_out), 32'h0);
        check("rst_valid", 32'(sample_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_timeout", 32'(timeout_err), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // basic assembly, latency one clock
        sample_ready = 1'b1;
        send_byte(8'h34);
        check("t1_partial_valid", 32'(sample_valid), 32'h0);
        send_byte(8'h12);
        check("t1_valid", 32'(sample_valid), 32'h1);
        check("t1_out", 32'(sample_out), 32'h1234);
        tick();
        check("t1_drop", 32'(sample_valid), 32'h0);

        // negative sample held while not ready
        sample_ready = 1'b0;
        send_byte(8'hFE);
        send_byte(8'hFF);
        check("t2_signed", 32'(sample_out), 32'hFFFF_FFFE);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_hold_out", 32'(sample_out), 32'hFFFF_FFFE);
            check("t2_hold_valid", 32'(sample_valid), 32'h1);
        end
        sample_ready = 1'b1;
        tick();
        check("t2_accept", 32'(sample_valid), 32'h0);

        // overrun
        sample_ready = 1'b0;
        send_byte(8'h01);
        send_byte(8'h00);
        check("t3_first", 32'(sample_out), 32'h0001);
        check("t3_no_ovr", 32'(overrun), 32'h0);
        send_byte(8'h02);
        send_byte(8'h00);
        check("t3_ovr_pulse", 32'(overrun), 32'h1);
        check("t3_out_kept", 32'(sample_out), 32'h0001);
        tick();
        check("t3_ovr_end", 32'(overrun), 32'h0);
        check("t3_out_kept2", 32'(sample_out), 32'h0001);
        sample_ready = 1'b1;
        tick();
        check("t3_accept", 32'(sample_valid), 32'h0);

        // timeout discards partial 0xAA
        send_byte(8'hAA);
        for (int i = 1; i < 20; i++) begin
            tick();
            check("t4_no_to_yet", 32'(timeout_err), 32'h0);
        end
        tick();
        check("t4_to_pulse", 32'(timeout_err), 32'h1);
        tick();
        check("t4_to_end", 32'(timeout_err), 32'h0);
        repeat (4) tick();
        send_byte(8'h11);
        send_byte(8'h22);
        check("t4_out", 32'(sample_out), 32'h2211);
        check("t4_valid", 32'(sample_valid), 32'h1);
        check("t4_to_quiet", 32'(timeout_err), 32'h0);
        tick();

        // byte in the expiry cycle wins
        send_byte(8'h33);
        for (int i = 1; i < 20; i++) begin
            tick();
            check("t5_no_to", 32'(timeout_err), 32'h0);
        end
        send_byte(8'h44);
        check("t5_no_to_edge", 32'(timeout_err), 32'h0);
        check("t5_out", 32'(sample_out), 32'h4433);
        check("t5_valid", 32'(sample_valid), 32'h1);
        tick();
        check("t5_no_to_after", 32'(timeout_err), 32'h0);
        check("t5_drop", 32'(sample_valid), 32'h0);

        // completion coinciding with accept
        sample_ready = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        check("t5b_first", 32'(sample_out), 32'h0201);
        send_byte(8'h03);
        sample_ready = 1'b1;
        send_byte(8'h04);
        check("t5b_valid", 32'(sample_valid), 32'h1);
        check("t5b_out", 32'(sample_out), 32'h0403);
        check("t5b_no_ovr", 32'(overrun), 32'h0);
        tick();
        check("t5b_drop", 32'(sample_valid), 32'h0);

        // asynchronous reset mid-sample
        sample_ready = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        check("t6_pre_valid", 32'(sample_valid), 32'h1);
        send_byte(8'h55);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(sample_valid), 32'h0);
        check("t6_rst_out", 32'(sample_out), 32'h0);
        check("t6_rst_ovr", 32'(overrun), 32'h0);
        check("t6_rst_to", 32'(timeout_err), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        send_byte(8'h66);
        send_byte(8'h77);
        check("t6_out", 32'(sample_out), 32'h7766);
        check("t6_valid", 32'(sample_valid), 32'h1);
        repeat (25) begin
            tick();
            check("t6_no_to", 32'(timeout_err), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
